// File: rtl/memz_stream_reader_if.sv
// Bundles the start command, Z-RAM read port and result stream of memz_stream_reader.
// master: the reader itself; slave: the command source / RAM / consumer side.
interface memz_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_addr_i;
    logic [ADDR_WIDTH:0]   length_i;
    logic [ADDR_WIDTH-1:0] read_addr_o;
    logic [DATA_WIDTH-1:0] read_data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] checksum_o;

    modport master (
        input  start_i, base_addr_i, length_i, read_data_i, ready_i,
        output read_addr_o, data_o, valid_o, busy_o, done_o, checksum_o
    );

    modport slave (
        output start_i, base_addr_i, length_i, read_data_i, ready_i,
        input  read_addr_o, data_o, valid_o, busy_o, done_o, checksum_o
    );
endinterface

// File: rtl/memz_stream_reader.sv
// Walks an address window of the Z RAM and streams the words out over valid/ready.
// Optional running checksum of transferred words: define MEMZ_STREAM_READER_CHECKSUM_EN.
module memz_stream_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input logic                  clk,
    input logic                  rst,
    memz_stream_reader_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   length_q;
    logic [ADDR_WIDTH:0]   issued_q;
    logic [ADDR_WIDTH-1:0] addr_hold_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  busy_q;
    logic                  done_q;

    logic [1:0]            occ;
    logic [1:0]            remaining;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [ADDR_WIDTH:0]   issued_nxt;
    logic                  xfer;
    logic                  push;
    logic                  pop;

    always_comb begin
        occ        = count_q + {1'b0, inflight_q};
        issue      = (state_q == StRun) && (issued_q < length_q) && (occ < 2'd2);
        issue_addr = base_q + issued_q[ADDR_WIDTH-1:0];
        issued_nxt = issued_q + 1'b1;
        xfer       = bus.valid_o & bus.ready_i;
        remaining  = occ - {1'b0, xfer};
        // The in-flight word is the FIFO head when the FIFO is empty, so it can
        // leave on its arrival cycle; it is only captured if it does not.
        push       = inflight_q && !((count_q == 2'd0) && xfer);
        pop        = xfer && (count_q != 2'd0);
    end

    assign bus.read_addr_o = issue ? issue_addr : addr_hold_q;
    assign bus.valid_o     = (count_q != 2'd0) || inflight_q;
    assign bus.data_o      = (count_q != 2'd0) ? fifo_q[rd_ptr_q] :
                             (inflight_q ? bus.read_data_i : '0);
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            length_q    <= '0;
            issued_q    <= '0;
            addr_hold_q <= '0;
            inflight_q  <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_q     <= 1'b0;
            if (issue) begin
                addr_hold_q <= issue_addr;
                issued_q    <= issued_nxt;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= bus.read_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase

            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        base_q   <= bus.base_addr_i;
                        length_q <= bus.length_i;
                        issued_q <= '0;
                        busy_q   <= 1'b1;
                        if (bus.length_i == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (issue && (issued_nxt == length_q)) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if (remaining == 2'd0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MEMZ_STREAM_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if ((state_q == StIdle) && bus.start_i) begin
            sum_q <= '0;
        end else if (xfer) begin
            sum_q <= sum_q + bus.data_o;
        end
    end

    assign bus.checksum_o = sum_q;
`else
    assign bus.checksum_o = '0;
`endif

endmodule

// File: doc/memz_stream_reader.md
Name: memz_stream_reader

Overview:
- Read-side sequencer for the convolution result memory (simple dual-port RAM, single clock, 1-cycle registered read).
- On a start command it walks a contiguous address window of the Z memory and drives the RAM read port.
- Absorbs the RAM's 1-cycle read latency and emits each word on a valid/ready output stream toward the host/transfer logic.
- Sits between the Z RAM read port and the result-export path.

Parameters:
DATA_WIDTH, 16, width of each stored/streamed word
ADDR_WIDTH, 6, RAM address width; window length up to 2**ADDR_WIDTH

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
start_i  input  1  start pulse; accepted only in IDLE
base_addr_i  input  ADDR_WIDTH  first address of the window, sampled on accepted start
length_i  input  ADDR_WIDTH+1  number of words (0..2**ADDR_WIDTH), sampled on accepted start
read_addr_o  output  ADDR_WIDTH  RAM read address
read_data_i  input  DATA_WIDTH  RAM read data, valid 1 cycle after read_addr_o is presented
data_o  output  DATA_WIDTH  stream data
valid_o  output  1  stream valid
ready_i  input  1  stream ready from consumer
busy_o  output  1  high from accepted start until done_o
done_o  output  1  1-cycle pulse after the last word transfers
checksum_o  output  DATA_WIDTH  see Optional Feature

Behaviour:
- Reset (async, rst=1): FSM=IDLE, read_addr_o=0, valid_o=0, data_o=0, busy_o=0, done_o=0, checksum_o=0, skid buffer empty, counters=0.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: start_i=1 latches base_addr_i/length_i. Goes to RUN, or to DONE directly if length_i=0.
  - RUN: issues reads. When the issued count reaches length, go to FLUSH.
  - FLUSH: waits until all in-flight and buffered words have transferred, then goes to DONE.
  - DONE: asserts done_o for exactly one cycle, then goes to IDLE.
- start_i outside IDLE is ignored; latched parameters do not change mid-operation.
- Read issue:
  - A read is issued in a cycle when state=RUN, issued<length, and (buffer occupancy + in-flight reads) < 2.
  - Issuing drives read_addr_o = base + issued (mod 2**ADDR_WIDTH), and marks an in-flight flag for the next cycle.
  - read_addr_o holds its last value when not issuing.
- Skid buffer:
  - 2-entry FIFO captures read_data_i on the cycle after each issue.
  - data_o/valid_o come from the FIFO head.
  - Transfer occurs when valid_o & ready_i.
  - A simultaneous push and pop leaves occupancy unchanged.
  - The FIFO never overflows; the credit rule above guarantees this.
- Throughput/latency:
  - With ready_i held 1, the first valid_o appears 2 cycles after the start cycle.
  - Sustained rate is 1 word/cycle.
  - done_o pulses the cycle after the last transfer.
- Address wrap: base + n wraps modulo 2**ADDR_WIDTH. Example: base=62, length=4 reads 62,63,0,1.
- Full window: length=2**ADDR_WIDTH reads every address exactly once.
- Backpressure:
  - While ready_i=0, valid_o and data_o are held stable.
  - Issuing stalls once 2 words are buffered or in flight.
- busy_o = (state != IDLE), including the DONE cycle.
- Reset mid-operation returns to the reset values immediately. Buffered words are discarded and no done_o is produced.

Optional Feature:
- Macro: MEMZ_STREAM_READER_CHECKSUM_EN.
- With the macro defined:
  - checksum_o is cleared on accepted start.
  - Each transferred word is added to it modulo 2**DATA_WIDTH.
  - The final sum is valid while done_o=1 and holds until the next accepted start.
- Without the macro: checksum_o is tied to 0 and no accumulator logic exists.

Test Plan:
- Preload RAM[i]=16'h0100+i. Apply start with base=0, length=8, ready_i=1 -> data_o 0100..0107 on consecutive cycles, first valid_o 2 cycles after start, done_o 1 cycle after 0107 transfers, busy_o low the cycle after done.
- base=62, length=4 -> read_addr_o sequence 62,63,0,1; data_o = RAM[62],RAM[63],RAM[0],RAM[1].
- length=8 with ready_i toggling 1,0,0,1 repeating -> all 8 words in order, none duplicated or lost, data_o stable while ready_i=0, never more than 2 outstanding reads.
- length=0 -> no valid_o, done_o pulses 1 cycle after start, read_addr_o unchanged; start_i pulses while busy are ignored (length stays as latched).
- Assert rst mid-run after 3 transfers -> valid_o/busy_o drop immediately, no done_o. A new start with base=0, length=2 then streams RAM[0],RAM[1].
- With MEMZ_STREAM_READER_CHECKSUM_EN, RAM[i]=16'hFFFF, length=3 -> checksum_o=16'hFFFD at done_o. Without the macro, checksum_o stays 0.
